// File: rtl/key_rotate_mux.sv
// key_rotate_mux
//   Key-schedule rotator for a split (C/D) key. A Start in IDLE loads both
//   halves already rotated for round 1. Each Advance then steps the halves
//   to the next round until the last round is consumed. Encrypt rotates
//   left and decrypt rotates right, by 1 or 2 bit positions per round as
//   selected by SHIFT_MAP.
//
// Parameters
//   WIDTH     width of each key half
//   ROUNDS    rounds per schedule (2..32)
//   SHIFT_MAP bit k-1: encrypt shift for round k (0 -> 1 bit, 1 -> 2 bits)
//
// Ports
//   Clk, Rst_n        clock, asynchronous active-low reset
//   Start, Mode       load request; Mode 0 = encrypt, 1 = decrypt
//   Advance           consumer step request
//   In_c, In_d        halves to load
//   Ready             IDLE, Start will be accepted
//   Valid             Out_c/Out_d/Round hold a valid round
//   Done              one-cycle pulse after the final round is consumed
//   Round             current round, 1..ROUNDS
//   Out_c, Out_d      registered halves for the current round
module key_rotate_mux #(
  parameter int unsigned           WIDTH     = 28,
  parameter int unsigned           ROUNDS    = 16,
  parameter logic [ROUNDS-1:0]     SHIFT_MAP = 16'h7EFC
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         Start,
  input  logic                         Mode,
  input  logic                         Advance,
  input  logic [WIDTH-1:0]             In_c,
  input  logic [WIDTH-1:0]             In_d,
  output logic                         Ready,
  output logic                         Valid,
  output logic                         Done,
  output logic [$clog2(ROUNDS+1)-1:0]  Round,
  output logic [WIDTH-1:0]             Out_c,
  output logic [WIDTH-1:0]             Out_d
);

  localparam int unsigned RW = $clog2(ROUNDS + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic             mode_q;
  logic [RW-1:0]    round_q;
  logic [WIDTH-1:0] c_q, d_q;
  logic             done_q;

  logic             load, step, finish;
  logic             rot_dir;
  logic [RW-1:0]    rot_round;
  logic [1:0]       rot_amt;
  logic [WIDTH-1:0] c_src, d_src, c_nxt, d_nxt;

  // Rotation amount used to enter round k. Decrypt walks the encrypt
  // schedule backwards and applies no shift on its first round.
  function automatic logic [1:0] shift_amt(input logic dec, input logic [RW-1:0] k);
    int unsigned       idx;
    logic [ROUNDS-1:0] sel;
    if (dec && (k == RW'(1)))
      return 2'd0;
    idx = dec ? (ROUNDS + 1 - 32'(k)) : (32'(k) - 1);
    sel = SHIFT_MAP >> idx;
    return sel[0] ? 2'd2 : 2'd1;
  endfunction

  // Circular rotate via a doubled word: the wanted window never sees fill bits.
  function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] x,
                                              input logic right,
                                              input logic [1:0] amt);
    logic [2*WIDTH-1:0] dbl;
    if (right) begin
      dbl = {x, x} >> amt;
      return dbl[WIDTH-1:0];
    end
    dbl = {x, x} << amt;
    return dbl[2*WIDTH-1:WIDTH];
  endfunction

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (Advance) begin
          if (round_q == RW'(ROUNDS)) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One shared rotator per half: the load path and the step path differ
  // only in source word, direction and target round.
  always_comb begin
    c_src     = load ? In_c : c_q;
    d_src     = load ? In_d : d_q;
    rot_dir   = load ? Mode : mode_q;
    rot_round = load ? RW'(1) : (round_q + RW'(1));
    rot_amt   = shift_amt(rot_dir, rot_round);
    c_nxt     = rotate(c_src, rot_dir, rot_amt);
    d_nxt     = rotate(d_src, rot_dir, rot_amt);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mode_q  <= 1'b0;
      round_q <= '0;
      c_q     <= '0;
      d_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= finish;
      if (load) mode_q <= Mode;
      if (load || step) begin
        round_q <= rot_round;
        c_q     <= c_nxt;
        d_q     <= d_nxt;
      end
    end
  end

  assign Ready = (state_q == IDLE);
  assign Valid = (state_q == RUN);
  assign Done  = done_q;
  assign Round = round_q;
  assign Out_c = c_q;
  assign Out_d = d_q;

endmodule

// File: tb/tb_key_rotate_mux.sv
module tb_key_rotate_mux;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic        Mode;
  logic        Advance;
  logic [27:0] In_c;
  logic [27:0] In_d;
  logic        Ready;
  logic        Valid;
  logic        Done;
  logic [4:0]  Round;
  logic [27:0] Out_c;
  logic [27:0] Out_d;

  int errors = 0;
  int checks = 0;

  key_rotate_mux #(
    .WIDTH(28),
    .ROUNDS(16),
    .SHIFT_MAP(16'h7EFC)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Mode(Mode), .Advance(Advance),
    .In_c(In_c), .In_d(In_d), .Ready(Ready), .Valid(Valid), .Done(Done),
    .Round(Round), .Out_c(Out_c), .Out_d(Out_d)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        ready;
    logic        valid;
    logic        done;
    logic [4:0]  round;
    logic [27:0] c;
    logic [27:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model state
  logic [15:0] sm = 16'h7EFC;
  logic        m_run;
  logic        m_mode;
  logic        m_done;
  int          m_round;
  logic [27:0] m_c, m_d;

  function automatic logic [27:0] mrot(input logic [27:0] x, input logic right, input int n);
    logic [27:0] r;
    r = x;
    for (int i = 0; i < n; i++)
      r = right ? {r[0], r[27:1]} : {r[26:0], r[27]};
    return r;
  endfunction

  function automatic int sm_bit(input int idx);
    logic [15:0] t;
    t = sm >> idx;
    return t[0] ? 2 : 1;
  endfunction

  function automatic int mamt(input logic dec, input int k);
    if (dec) begin
      if (k == 1) return 0;
      return sm_bit(17 - k);
    end
    return sm_bit(k - 1);
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_mode = 1'b0; m_done = 1'b0; m_round = 0; m_c = '0; m_d = '0;
    sb.delete();
  endtask

  // Drive one clock of stimulus, advance the model and queue its expectation.
  task automatic drive(input logic st, input logic md, input logic adv,
                       input logic [27:0] c, input logic [27:0] d);
    exp_t e;
    @(negedge Clk);
    Start = st; Mode = md; Advance = adv; In_c = c; In_d = d;
    m_done = 1'b0;
    if (!m_run) begin
      if (st) begin
        m_mode  = md;
        m_round = 1;
        m_c     = mrot(c, md, mamt(md, 1));
        m_d     = mrot(d, md, mamt(md, 1));
        m_run   = 1'b1;
      end
    end else if (adv) begin
      if (m_round == 16) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end else begin
        m_round = m_round + 1;
        m_c     = mrot(m_c, m_mode, mamt(m_mode, m_round));
        m_d     = mrot(m_d, m_mode, mamt(m_mode, m_round));
      end
    end
    e.ready = !m_run;
    e.valid = m_run;
    e.done  = m_done;
    e.round = 5'(m_round);
    e.c     = m_c;
    e.d     = m_d;
    sb.push_back(e);
    @(posedge Clk);
    #2;
  endtask

  task automatic finish_schedule();
    for (int i = 0; i < 40 && m_run; i++)
      drive(1'b0, 1'b0, 1'b1, '0, '0);
  endtask

  // Scoreboard: compare every queued expectation just after its edge.
  always @(posedge Clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if ({Ready, Valid, Done, Round, Out_c, Out_d} !==
          {mon_e.ready, mon_e.valid, mon_e.done, mon_e.round, mon_e.c, mon_e.d}) begin
        errors++;
        $display("FAIL scoreboard t=%0t got rdy=%b vld=%b done=%b rnd=%0d c=%h d=%h expected rdy=%b vld=%b done=%b rnd=%0d c=%h d=%h",
                 $time, Ready, Valid, Done, Round, Out_c, Out_d,
                 mon_e.ready, mon_e.valid, mon_e.done, mon_e.round, mon_e.c, mon_e.d);
      end
    end
  end

  task automatic test_reset();
    #3;
    checks++;
    if ({Ready, Valid, Done, Round, Out_c, Out_d} !== {1'b1, 1'b0, 1'b0, 5'd0, 28'h0, 28'h0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b done=%b rnd=%0d c=%h d=%h expected 1 0 0 0 0 0",
               Ready, Valid, Done, Round, Out_c, Out_d);
    end
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_encrypt();
    drive(1'b1, 1'b0, 1'b0, 28'h0001234, 28'h000FFFF);
    checks++;
    if ({Round, Out_c, Out_d} !== {5'd1, 28'h0002468, 28'h001FFFE}) begin
      errors++;
      $display("FAIL enc_round1 got rnd=%0d c=%h d=%h expected 1 0002468 001fffe", Round, Out_c, Out_d);
    end
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    checks++;
    if ({Round, Out_c} !== {5'd2, 28'h00048D0}) begin
      errors++;
      $display("FAIL enc_round2 got rnd=%0d c=%h expected 2 00048d0", Round, Out_c);
    end
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    checks++;
    if ({Round, Out_c} !== {5'd3, 28'h0012340}) begin
      errors++;
      $display("FAIL enc_round3 got rnd=%0d c=%h expected 3 0012340", Round, Out_c);
    end
    finish_schedule();
  endtask

  task automatic test_full_schedule();
    drive(1'b1, 1'b0, 1'b1, 28'h0001234, 28'h000FFFF);
    for (int i = 2; i <= 16; i++) begin
      drive(1'b0, 1'b0, 1'b1, '0, '0);
      checks++;
      if (Round !== 5'(i)) begin
        errors++;
        $display("FAIL full_round_step got %0d expected %0d", Round, i);
      end
    end
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    checks++;
    if ({Done, Valid, Ready, Round, Out_c, Out_d} !== {1'b1, 1'b0, 1'b1, 5'd16, 28'h0001234, 28'h000FFFF}) begin
      errors++;
      $display("FAIL full_done got done=%b vld=%b rdy=%b rnd=%0d c=%h d=%h expected 1 0 1 16 0001234 000ffff",
               Done, Valid, Ready, Round, Out_c, Out_d);
    end
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    checks++;
    if ({Done, Valid} !== 2'b00) begin
      errors++;
      $display("FAIL done_single_pulse got done=%b vld=%b expected 0 0", Done, Valid);
    end
  endtask

  task automatic test_decrypt();
    drive(1'b1, 1'b1, 1'b0, 28'h0000001, 28'($urandom));
    checks++;
    if ({Round, Out_c} !== {5'd1, 28'h0000001}) begin
      errors++;
      $display("FAIL dec_round1 got rnd=%0d c=%h expected 1 0000001", Round, Out_c);
    end
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    checks++;
    if ({Round, Out_c} !== {5'd2, 28'h8000000}) begin
      errors++;
      $display("FAIL dec_round2_wrap got rnd=%0d c=%h expected 2 8000000", Round, Out_c);
    end
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    checks++;
    if ({Round, Out_c} !== {5'd3, 28'h2000000}) begin
      errors++;
      $display("FAIL dec_round3 got rnd=%0d c=%h expected 3 2000000", Round, Out_c);
    end
    finish_schedule();
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b0, 1'b0, 28'($urandom), 28'($urandom));
    repeat (3) drive(1'b0, 1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 5; i++) begin
      drive((i == 2), 1'b1, 1'b0, 28'($urandom), 28'($urandom));
      checks++;
      if ({Valid, Ready, Round, Out_c, Out_d} !== {1'b1, 1'b0, 5'd4, m_c, m_d}) begin
        errors++;
        $display("FAIL hold_frozen cyc=%0d got vld=%b rdy=%b rnd=%0d c=%h d=%h expected 1 0 4 %h %h",
                 i, Valid, Ready, Round, Out_c, Out_d, m_c, m_d);
      end
    end
    finish_schedule();
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b1, 1'b0, 28'($urandom), 28'($urandom));
    repeat (6) drive(1'b0, 1'b0, 1'b1, '0, '0);
    #1;
    Rst_n = 1'b0;
    #1;
    checks++;
    if ({Ready, Valid, Done, Round, Out_c, Out_d} !== {1'b1, 1'b0, 1'b0, 5'd0, 28'h0, 28'h0}) begin
      errors++;
      $display("FAIL mid_reset got rdy=%b vld=%b done=%b rnd=%0d c=%h d=%h expected 1 0 0 0 0 0",
               Ready, Valid, Done, Round, Out_c, Out_d);
    end
    model_reset();
    Start = 1'b0; Advance = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 28'h0001234, 28'h000FFFF);
    checks++;
    if ({Valid, Round, Out_c, Out_d} !== {1'b1, 5'd1, 28'h0002468, 28'h001FFFE}) begin
      errors++;
      $display("FAIL post_reset_load got vld=%b rnd=%0d c=%h d=%h expected 1 1 0002468 001fffe",
               Valid, Round, Out_c, Out_d);
    end
    finish_schedule();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 1'b1, 28'($urandom), 28'($urandom));
    checks++;
    if ({Valid, Round} !== {1'b1, 5'd1}) begin
      errors++;
      $display("FAIL start_with_advance got vld=%b rnd=%0d expected 1 1", Valid, Round);
    end
    repeat (16) drive(1'b0, 1'b0, 1'b1, '0, '0);
    checks++;
    if (Done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done got %b expected 1", Done);
    end
    drive(1'b1, 1'b1, 1'b0, 28'h0000001, 28'h0000002);
    checks++;
    if ({Done, Valid, Round, Out_c, Out_d} !== {1'b0, 1'b1, 5'd1, 28'h0000001, 28'h0000002}) begin
      errors++;
      $display("FAIL b2b_reload got done=%b vld=%b rnd=%0d c=%h d=%h expected 0 1 1 0000001 0000002",
               Done, Valid, Round, Out_c, Out_d);
    end
    finish_schedule();
  endtask

  initial begin
    Rst_n = 1'b0; Start = 1'b0; Mode = 1'b0; Advance = 1'b0; In_c = '0; In_d = '0;
    model_reset();
    test_reset();
    test_encrypt();
    test_full_schedule();
    test_decrypt();
    test_hold();
    test_mid_reset();
    test_back_to_back();
    @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
